key_conditioner: RTL and testbench

Parametrised multi-channel input conditioner for the board's push-buttons and switches. It is the next generation of the single-bit `synchronizer`. Each channel gets:
- polarity normalisation and a multi-flop synchronizer;
- a counter-based debouncer;
- registered press/release one-shot pulses.

It sits between the raw board inputs and the game FSM, and optionally generates auto-repeat pulses for held keys (menu scrolling).

---
 rtl/key_conditioner.sv | 114 +++++++++++
 tb/tb_key_conditioner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-channel polarity normalisation, synchronizer, counter debouncer and
// registered press/release pulses. Optional auto-repeat on held keys via KEY_COND_AUTOREPEAT_EN.
module key_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_COND_AUTOREPEAT_EN
    localparam int RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W    = (RPT_SPAN > 1) ? $clog2(RPT_SPAN) : 1;
    // Down-counter reload values: a pulse fires when the counter has reached zero.
    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);
`else
    // Repeat parameters have no function without the auto-repeat build.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    logic [WIDTH-1:0] w_norm;

    assign w_norm = ACTIVE_LOW ? ~data_in : data_in;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_stable;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_press;
        logic                   r_release;
        logic                   w_sync;
        logic                   w_accept;
        logic                   w_rise;
        logic                   w_fall;

        assign w_sync   = r_sync[SYNC_STAGES-1];
        assign w_accept = (w_sync != r_stable) && (r_cnt == CNT_MAX);
        assign w_rise   = w_accept &  w_sync;
        assign w_fall   = w_accept & ~w_sync;

        // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (reset) begin
                // NOTE: sync flops clear to the normalised inactive value, so an idle pin yields no pulse.
                r_sync    <= '0;
                r_stable  <= 1'b0;
                r_cnt     <= '0;
                r_release <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_norm[g]};
                if (w_sync == r_stable) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_stable <= w_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_release <= w_fall;
            end
        end

`ifdef KEY_COND_AUTOREPEAT_EN
        logic [RPT_W-1:0] r_rpt;
        logic             w_repeat;

        // A release edge suppresses any repeat that would coincide with it.
        assign w_repeat = r_stable && !w_fall && (r_rpt == '0);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rpt   <= '0;
                r_press <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_rpt <= RPT_DELAY_LD;
                end else if (!r_stable || w_fall) begin
                    r_rpt <= '0;
                end else if (w_repeat) begin
                    r_rpt <= RPT_PERIOD_LD;
                end else begin
                    r_rpt <= r_rpt - 1'b1;
                end
                r_press <= w_rise | w_repeat;
            end
        end
`else
        always_ff @(posedge clk) begin
            if (reset) begin
                r_press <= 1'b0;
            end else begin
                r_press <= w_rise;
            end
        end
`endif

        assign level_out[g]     = r_stable;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a window-based reference model predicts every cycle's
// outputs, a separate monitor compares them mid-cycle.
module tb_key_conditioner;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = 4'hF;
    logic [W-1:0] level_out;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    key_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #10 clk = ~clk;

    typedef struct {
        int           edge_no;
        logic [W-1:0] level;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: captured normalised words (oldest first), the last D
    // synchronized samples seen by the debouncer, the accepted level, cycles since press.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_win[$];
    logic [W-1:0] m_stable;
    int           m_since[W];

    task automatic model_edge(input logic [W-1:0] d, input logic r, output exp_t e);
        logic [W-1:0] sync_pre;
        logic [W-1:0] flip;
        logic [W-1:0] press;
        logic [W-1:0] rel;
        press = '0;
        rel   = '0;
        if (r) begin
            m_hist = {};
            m_win  = {};
            for (int k = 0; k < S; k++) m_hist.push_back('0);
            for (int k = 0; k < D; k++) m_win.push_back('0);
            m_stable = '0;
            for (int i = 0; i < W; i++) m_since[i] = -1;
        end else begin
            sync_pre = m_hist[0];
            m_win.push_back(sync_pre);
            void'(m_win.pop_front());
            // A channel flips once its last D samples all disagree with the accepted level.
            flip = '1;
            foreach (m_win[k]) flip &= m_win[k] ^ m_stable;
            press    = flip & ~m_stable;
            rel      = flip & m_stable;
            m_stable = m_stable ^ flip;
            m_hist.push_back(~d);
            void'(m_hist.pop_front());
`ifdef KEY_COND_AUTOREPEAT_EN
            for (int i = 0; i < W; i++) begin
                if (press[i]) begin
                    m_since[i] = 0;
                end else if (rel[i]) begin
                    m_since[i] = -1;
                end else if (m_since[i] >= 0) begin
                    m_since[i]++;
                    if (m_since[i] >= RD && ((m_since[i] - RD) % RP) == 0) press[i] = 1'b1;
                end
            end
`endif
        end
        e.edge_no = 0;
        e.level   = m_stable;
        e.press   = press;
        e.rel     = rel;
    endtask

    task automatic apply(input logic [W-1:0] d, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        data_in = d;
        reset   = r;
        model_edge(d, r, e);
        e.edge_no = edge_cnt + 1;
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Monitor: outputs are valid every cycle; pop the expectation tagged for this edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
            e = sb_q.pop_front();
            n_vec++;
            if (e.edge_no != edge_cnt || level_out !== e.level ||
                press_pulse !== e.press || release_pulse !== e.rel) begin
                n_err++;
                $display("FAIL outputs edge %0d (exp edge %0d): level %h/%h press %h/%h release %h/%h (got/exp)",
                         edge_cnt, e.edge_no, level_out, e.level, press_pulse, e.press,
                         release_pulse, e.rel);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] rnd_d;
        logic         rnd_r;

        // Reset with inputs idle, then idle: no pulses expected.
        repeat (3) apply(4'hF, 1'b1);
        repeat (20) apply(4'hF, 1'b0);

        // Clean press and release on channel 0.
        repeat (8) apply(4'hE, 1'b0);
        repeat (8) apply(4'hF, 1'b0);

        // Bounce on channel 1: 2-cycle toggles, then a solid press and release.
        for (int i = 0; i < 12; i++) apply(((i / 2) % 2 == 0) ? 4'hD : 4'hF, 1'b0);
        repeat (10) apply(4'hD, 1'b0);
        repeat (10) apply(4'hF, 1'b0);

        // Simultaneous press and release of every channel.
        repeat (8) apply(4'h0, 1'b0);
        repeat (8) apply(4'hF, 1'b0);

        // Reset in the middle of debouncing channel 2, key kept held afterwards.
        repeat (2) apply(4'hB, 1'b0);
        repeat (2) apply(4'hB, 1'b1);
        repeat (10) apply(4'hB, 1'b0);
        repeat (8) apply(4'hF, 1'b0);

        // Long hold on channel 3 (repeat pulses in the auto-repeat build).
        repeat (36) apply(4'h7, 1'b0);
        repeat (10) apply(4'hF, 1'b0);

        // Random bouncing on all channels with occasional resets.
        rnd_d = 4'hF;
        for (int n = 0; n < 500; n++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) rnd_d[b] = ~rnd_d[b];
            end
            rnd_r = ($urandom_range(0, 149) == 0);
            apply(rnd_d, rnd_r);
        end
        repeat (12) apply(4'hF, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
